dram_arbiter: RTL and testbench

- Shares the single image data DRAM between two requesters: the downsampling processor (CPU port) and a host loader/unloader (HOST port).
- The host fills the source image before `enable` and reads the result after `finish`; both ports may contend at any time.
- Sits between the requesters and the DRAM. Owns the memory address, data and strobe pins, arbitrates fairly and returns a one-cycle acknowledge per access.

---
 rtl/dram_arbiter_if.sv | 51 +++++
 rtl/dram_arbiter.sv | 119 +++++++++++
 tb/tb_dram_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two DRAM requesters (CPU, host), the arbiter and
// the DRAM. The slave view belongs to the arbiter. The master view belongs to
// the environment: the requesters plus the memory.
interface dram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // CPU port
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;
  // host port
  logic              host_rd;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  // DRAM pins
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // ownership indicator
  logic              grant_host;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  host_rd, host_wr, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output host_rdata, host_ack,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output grant_host
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output host_rd, host_wr, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  host_rdata, host_ack,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  grant_host
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port round-robin DRAM arbiter. It serves one access at a time:
// IDLE picks a port, ACCESS drives the strobes, and DONE returns a one-cycle
// ack to the port that was served.
module dram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  dram_arbiter_if.slave bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic              sel_host;
  logic              last_host;
  logic              grant_host_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;

  logic cpu_req, host_req, any_req, pick_host, last_cycle;

  assign cpu_req  = bus.cpu_rd | bus.cpu_wr;
  assign host_req = bus.host_rd | bus.host_wr;
  assign any_req  = cpu_req | host_req;
  // On a tie, the port that was not served last wins.
  assign pick_host = host_req & (~cpu_req | ~last_host);
  // A write takes a single ACCESS cycle. A read ends when the count reaches 0.
  assign last_cycle = op_wr | (cnt == '0);

  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.grant_host = grant_host_q;
  assign bus.cpu_stall  = cpu_req & ~bus.cpu_ack;

  // State register. Reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and strobe/ack decode. The outputs come straight from the
  // state, so reset clears them in the same cycle.
  always_comb begin
    state_nxt    = state;
    bus.mem_re   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.cpu_ack  = 1'b0;
    bus.host_ack = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_we = op_wr;
        bus.mem_re = ~op_wr;
        if (last_cycle) state_nxt = DONE;
      end
      DONE: begin
        bus.cpu_ack  = ~sel_host;
        bus.host_ack = sel_host;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, read latency counter and per-port read data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      op_wr        <= 1'b0;
      sel_host     <= 1'b0;
      last_host    <= 1'b1;
      grant_host_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_host     <= pick_host;
            last_host    <= pick_host;
            grant_host_q <= pick_host;
            // rd and wr together count as a write
            op_wr        <= pick_host ? bus.host_wr    : bus.cpu_wr;
            addr_q       <= pick_host ? bus.host_addr  : bus.cpu_addr;
            wdata_q      <= pick_host ? bus.host_wdata : bus.cpu_wdata;
            cnt          <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (!op_wr) begin
            if (cnt == '0) begin
              if (sel_host) host_rdata_q <= bus.mem_rdata;
              else          cpu_rdata_q  <= bus.mem_rdata;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter. It uses a small DRAM model that presents
// read data only in the MEM_LAT-th consecutive mem_re cycle.
module tb_dram_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model
  logic [DATA_W-1:0] mem [256];
  int re_cycles;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (rst || !bus.mem_re) re_cycles <= 0;
    else                    re_cycles <= re_cycles + 1;
  end

  assign bus.mem_rdata = (bus.mem_re && re_cycles == MEM_LAT - 1) ?
                         mem[bus.mem_addr[7:0]] : 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_rd = 0; bus.host_wr = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_reqs();
    tick();
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin failures++;
      $display("FAIL rst_strobes: re=%b we=%b required 0 0", bus.mem_re, bus.mem_we); end
    checks++; if (bus.cpu_ack !== 1'b0 || bus.host_ack !== 1'b0) begin failures++;
      $display("FAIL rst_acks: cpu=%b host=%b required 0 0", bus.cpu_ack, bus.host_ack); end
    checks++; if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin failures++;
      $display("FAIL rst_mem_bus: addr=%h wdata=%h required 0000 00", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_rdata !== 8'h00 || bus.host_rdata !== 8'h00) begin failures++;
      $display("FAIL rst_rdata: cpu=%h host=%h required 00 00", bus.cpu_rdata, bus.host_rdata); end
    checks++; if (bus.grant_host !== 1'b0 || bus.cpu_stall !== 1'b0) begin failures++;
      $display("FAIL rst_grant_stall: grant=%b stall=%b required 0 0", bus.grant_host, bus.cpu_stall); end
    rst = 1'b0;
  endtask

  // Cycle 0 is the current cycle (IDLE).
  task automatic test_cpu_write;
    bus.cpu_wr = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'hA5;
    #1;
    checks++; if (bus.cpu_stall !== 1'b1) begin failures++;
      $display("FAIL wr_stall_c0: got %b required 1", bus.cpu_stall); end
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0) begin failures++;
      $display("FAIL wr_strobe_c1: we=%b re=%b required 1 0", bus.mem_we, bus.mem_re); end
    checks++; if (bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 8'hA5) begin failures++;
      $display("FAIL wr_bus_c1: addr=%h wdata=%h required 0010 a5", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++;
      $display("FAIL wr_early_ack: got %b required 0", bus.cpu_ack); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.mem_we !== 1'b0 || bus.host_ack !== 1'b0) begin failures++;
      $display("FAIL wr_ack_c2: ack=%b we=%b hack=%b required 1 0 0", bus.cpu_ack, bus.mem_we, bus.host_ack); end
    checks++; if (bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== 8'h00) begin failures++;
      $display("FAIL wr_stall_rdata_c2: stall=%b rdata=%h required 0 00", bus.cpu_stall, bus.cpu_rdata); end
    clear_reqs();
  endtask

  task automatic test_host_read;
    tick();
    bus.host_rd = 1; bus.host_addr = 16'h0010;
    tick();
    checks++; if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.grant_host !== 1'b1) begin failures++;
      $display("FAIL rd_c1: re=%b we=%b grant=%b required 1 0 1", bus.mem_re, bus.mem_we, bus.grant_host); end
    checks++; if (bus.mem_addr !== 16'h0010) begin failures++;
      $display("FAIL rd_addr_c1: got %h required 0010", bus.mem_addr); end
    tick();
    checks++; if (bus.mem_re !== 1'b1 || bus.host_ack !== 1'b0) begin failures++;
      $display("FAIL rd_c2: re=%b ack=%b required 1 0", bus.mem_re, bus.host_ack); end
    tick();
    checks++; if (bus.host_ack !== 1'b1 || bus.mem_re !== 1'b0 || bus.cpu_ack !== 1'b0) begin failures++;
      $display("FAIL rd_ack_c3: ack=%b re=%b cack=%b required 1 0 0", bus.host_ack, bus.mem_re, bus.cpu_ack); end
    checks++; if (bus.host_rdata !== 8'hA5 || bus.cpu_rdata !== 8'h00) begin failures++;
      $display("FAIL rd_data_c3: host=%h cpu=%h required a5 00", bus.host_rdata, bus.cpu_rdata); end
    clear_reqs();
  endtask

  // Both ports write in the same cycle, twice. The CPU goes first each time.
  task automatic test_tie;
    logic [7:0] cdat [2];
    logic [7:0] hdat [2];
    int cyc, cpu_at, host_at;
    cdat[0] = 8'h11; hdat[0] = 8'h22; cdat[1] = 8'h33; hdat[1] = 8'h44;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      bus.cpu_wr = 1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = cdat[rep];
      bus.host_wr = 1; bus.host_addr = 16'h0021; bus.host_wdata = hdat[rep];
      cyc = 0; cpu_at = -1; host_at = -1;
      while ((cpu_at < 0 || host_at < 0) && cyc < 20) begin
        tick();
        cyc++;
        checks++; if (bus.cpu_ack === 1'b1 && bus.host_ack === 1'b1) begin failures++;
          $display("FAIL tie_dual_ack: rep %0d cycle %0d both acks high", rep, cyc); end
        if (bus.cpu_ack === 1'b1) begin cpu_at = cyc; bus.cpu_wr = 0; end
        if (bus.host_ack === 1'b1) begin host_at = cyc; bus.host_wr = 0; end
      end
      checks++; if (cpu_at != 2 || host_at != 5) begin failures++;
        $display("FAIL tie_order: rep %0d cpu_ack@%0d host_ack@%0d required 2 5", rep, cpu_at, host_at); end
      checks++; if (mem[8'h20] !== cdat[rep] || mem[8'h21] !== hdat[rep]) begin failures++;
        $display("FAIL tie_mem: rep %0d got %h %h required %h %h", rep, mem[8'h20], mem[8'h21], cdat[rep], hdat[rep]); end
    end
    clear_reqs();
  endtask

  // The CPU read stays high throughout while the host issues two writes.
  task automatic test_hold_read;
    int exp_host [4];
    int exp_cyc [4];
    int cyc, n;
    exp_host[0] = 0; exp_host[1] = 1; exp_host[2] = 0; exp_host[3] = 1;
    exp_cyc[0] = 3;  exp_cyc[1] = 6;  exp_cyc[2] = 10; exp_cyc[3] = 13;
    tick();
    bus.cpu_rd = 1; bus.cpu_addr = 16'h0020;
    bus.host_wr = 1; bus.host_addr = 16'h0030; bus.host_wdata = 8'h55;
    cyc = 0; n = 0;
    while (n < 4 && cyc < 30) begin
      tick();
      cyc++;
      checks++; if (bus.cpu_stall !== ~bus.cpu_ack) begin failures++;
        $display("FAIL hold_stall: cycle %0d stall=%b ack=%b", cyc, bus.cpu_stall, bus.cpu_ack); end
      checks++; if (bus.mem_re === 1'b1 && bus.mem_we === 1'b1) begin failures++;
        $display("FAIL hold_dual_strobe: cycle %0d re and we both high", cyc); end
      if (bus.cpu_ack === 1'b1 || bus.host_ack === 1'b1) begin
        checks++; if (int'(bus.host_ack) != exp_host[n] || cyc != exp_cyc[n]) begin failures++;
          $display("FAIL hold_grant: ack %0d host=%b at cycle %0d required host=%0d at %0d",
                   n, bus.host_ack, cyc, exp_host[n], exp_cyc[n]); end
        if (bus.cpu_ack === 1'b1) begin
          checks++; if (bus.cpu_rdata !== 8'h33) begin failures++;
            $display("FAIL hold_rdata: got %h required 33", bus.cpu_rdata); end
        end
        if (bus.host_ack === 1'b1) begin bus.host_addr = 16'h0031; bus.host_wdata = 8'h66; end
        n++;
      end
    end
    clear_reqs();
    checks++; if (n != 4) begin failures++;
      $display("FAIL hold_timeout: got %0d acks required 4", n); end
    checks++; if (mem[8'h30] !== 8'h55 || mem[8'h31] !== 8'h66) begin failures++;
      $display("FAIL hold_mem: got %h %h required 55 66", mem[8'h30], mem[8'h31]); end
  endtask

  task automatic test_reset_mid;
    tick();
    bus.host_rd = 1; bus.host_addr = 16'h0030;
    tick();
    tick();
    checks++; if (bus.mem_re !== 1'b1 || bus.cpu_rdata !== 8'h33) begin failures++;
      $display("FAIL mid_pre: re=%b cpu_rdata=%h required 1 33", bus.mem_re, bus.cpu_rdata); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin failures++;
      $display("FAIL mid_strobes: re=%b we=%b required 0 0", bus.mem_re, bus.mem_we); end
    checks++; if (bus.cpu_rdata !== 8'h00 || bus.host_rdata !== 8'h00) begin failures++;
      $display("FAIL mid_rdata: cpu=%h host=%h required 00 00", bus.cpu_rdata, bus.host_rdata); end
    tick();
    checks++; if (bus.host_ack !== 1'b0 || bus.cpu_ack !== 1'b0) begin failures++;
      $display("FAIL mid_noack: host=%b cpu=%b required 0 0", bus.host_ack, bus.cpu_ack); end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c < 3) begin
        checks++; if (bus.host_ack !== 1'b0 || bus.mem_re !== 1'b1) begin failures++;
          $display("FAIL mid_reissue_c%0d: ack=%b re=%b required 0 1", c, bus.host_ack, bus.mem_re); end
      end else begin
        checks++; if (bus.host_ack !== 1'b1 || bus.host_rdata !== 8'h55) begin failures++;
          $display("FAIL mid_reissue_ack: ack=%b rdata=%h required 1 55", bus.host_ack, bus.host_rdata); end
      end
    end
    clear_reqs();
  endtask

  task automatic test_rdwr;
    tick();
    bus.cpu_rd = 1; bus.cpu_wr = 1; bus.cpu_addr = 16'h00FF; bus.cpu_wdata = 8'h3C;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0) begin failures++;
      $display("FAIL rdwr_strobe: we=%b re=%b required 1 0", bus.mem_we, bus.mem_re); end
    checks++; if (bus.mem_addr !== 16'h00FF || bus.mem_wdata !== 8'h3C) begin failures++;
      $display("FAIL rdwr_bus: addr=%h wdata=%h required 00ff 3c", bus.mem_addr, bus.mem_wdata); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h00) begin failures++;
      $display("FAIL rdwr_ack: ack=%b rdata=%h required 1 00", bus.cpu_ack, bus.cpu_rdata); end
    clear_reqs();
    tick();
    checks++; if (mem[8'hFF] !== 8'h3C || bus.cpu_ack !== 1'b0) begin failures++;
      $display("FAIL rdwr_mem: mem=%h ack=%b required 3c 0", mem[8'hFF], bus.cpu_ack); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_cpu_write();
    test_host_read();
    test_tie();
    test_hold_read();
    test_reset_mid();
    test_rdwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached before summary");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
